// File: rtl/debug_send_unit_if.sv
// Debug frame serializer bus: controller request, RF/DM read ports, UART tx.
// master = serializer side, slave = controller/memory/UART side.
interface debug_send_unit_if #(
  parameter int NBITS           = 32,
  parameter int REG_ADDR_LENGTH = 5,
  parameter int DM_ADDR_LENGTH  = 5
);
  logic                       send_flag;
  logic [NBITS-1:0]           pc;
  logic [NBITS-1:0]           rf_data;
  logic [NBITS-1:0]           dm_data;
  logic                       tx_done;
  logic [REG_ADDR_LENGTH-1:0] rf_addr;
  logic [DM_ADDR_LENGTH-1:0]  dm_addr;
  logic                       tx_start;
  logic [7:0]                 tx_data;
  logic                       send_done;

  modport master (
    input  send_flag, pc, rf_data, dm_data, tx_done,
    output rf_addr, dm_addr, tx_start, tx_data, send_done
  );

  modport slave (
    output send_flag, pc, rf_data, dm_data, tx_done,
    input  rf_addr, dm_addr, tx_start, tx_data, send_done
  );
endinterface

// File: rtl/debug_send_unit.sv
// Serializes PC, register file and a data-memory window to the UART,
// 4 bytes per word MSB first, then pulses send_done once.
module debug_send_unit #(
  parameter int NBITS           = 32,
  parameter int REG_ADDR_LENGTH = 5,
  parameter int NREGS           = 32,
  parameter int DM_ADDR_LENGTH  = 5,
  parameter int DM_WORDS        = 32
) (
  input  logic clk,
  input  logic reset,
  debug_send_unit_if.master bus
);

  localparam int NWORDS = 1 + NREGS + DM_WORDS;
  localparam int WW0    = $clog2(NWORDS + 1);
  localparam int AW     = (REG_ADDR_LENGTH > DM_ADDR_LENGTH) ?
                          REG_ADDR_LENGTH : DM_ADDR_LENGTH;
  localparam int WW     = (WW0 > AW) ? WW0 : AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [WW-1:0]              w_q, w_d;
  logic [1:0]                 byte_cnt_q, byte_cnt_d;
  logic [NBITS-1:0]           shift_q, shift_d;
  logic [REG_ADDR_LENGTH-1:0] rf_addr_q, rf_addr_d;
  logic [DM_ADDR_LENGTH-1:0]  dm_addr_q, dm_addr_d;

  logic last_byte;
  logic last_word;

  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = (w_q == WW'(NWORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.send_flag) state_d = S_ADDR;
      S_ADDR:  state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done) begin
          if (!last_byte)     state_d = S_START;
          else if (last_word) state_d = S_DONE;
          else                state_d = S_ADDR;
        end
      end
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  if (!bus.send_flag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address is registered on entry to ADDR so the synchronous
  // RF/DM read returns data during LOAD.
  always_comb begin
    w_d        = w_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rf_addr_d  = rf_addr_q;
    dm_addr_d  = dm_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.send_flag) begin
          w_d        = '0;
          byte_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (w_q == '0)
          shift_d = bus.pc;
        else if (w_q <= WW'(NREGS))
          shift_d = bus.rf_data;
        else
          shift_d = bus.dm_data;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          if (!last_byte) begin
            shift_d    = shift_q << 8;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else if (!last_word) begin
            w_d        = w_q + WW'(1);
            byte_cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_ADDR && state_q != S_ADDR) begin
      if (w_d != '0 && w_d <= WW'(NREGS))
        rf_addr_d = REG_ADDR_LENGTH'(w_d - WW'(1));
      else if (w_d > WW'(NREGS))
        dm_addr_d = DM_ADDR_LENGTH'(w_d - WW'(NREGS + 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q        <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rf_addr_q  <= '0;
      dm_addr_q  <= '0;
    end else begin
      w_q        <= w_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rf_addr_q  <= rf_addr_d;
      dm_addr_q  <= dm_addr_d;
    end
  end

  always_comb begin
    bus.tx_start  = 1'b0;
    bus.send_done = 1'b0;
    unique case (1'b1)
      (state_q == S_START): bus.tx_start  = 1'b1;
      (state_q == S_DONE):  bus.send_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.tx_data = shift_q[NBITS-1 -: 8];
  assign bus.rf_addr = rf_addr_q;
  assign bus.dm_addr = dm_addr_q;

endmodule

// File: doc/debug_send_unit.md
# debug_send_unit

Frame serializer downstream of the debug controller. When `send_flag` is raised after a step or HALT, it sends one fixed-format dump through the UART transmitter: PC, then every register-file word, then a window of data-memory words, each as 4 bytes MSB first. It pulses `send_done` once the last byte has left the UART, which releases the controller back to RECVMODE/RECVPROG.

## Interface
Parameters:
- `NBITS`, 32, word width of PC, register and memory data (must be 32: 4 bytes per word)
- `REG_ADDR_LENGTH`, 5, register-file read address width
- `NREGS`, 32, register words dumped (≤ 2^REG_ADDR_LENGTH)
- `DM_ADDR_LENGTH`, 5, data-memory read address width
- `DM_WORDS`, 32, data-memory words dumped, addresses 0..DM_WORDS-1 (≤ 2^DM_ADDR_LENGTH)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `send_flag`  in  NBITS-independent 1  level request from debug controller; held high until `send_done` seen
- `pc`  in  NBITS  current program counter, sampled when its word is loaded
- `rf_data`  in  NBITS  register-file read data, 1-cycle synchronous read of `rf_addr`
- `dm_data`  in  NBITS  data-memory read data, 1-cycle synchronous read of `dm_addr`
- `tx_done`  in  1  UART tx one-cycle pulse: byte fully transmitted
- `rf_addr`  out  REG_ADDR_LENGTH  register read address
- `dm_addr`  out  DM_ADDR_LENGTH  data-memory read address
- `tx_start`  out  1  one-cycle pulse: start transmitting `tx_data`
- `tx_data`  out  8  byte to transmit
- `send_done`  out  1  one-cycle pulse: frame complete

## Operation
- Frame: word index w = 0..NREGS+DM_WORDS. w=0 is `pc`; w=1..NREGS is `rf_data` at `rf_addr`=w-1; the remaining words are `dm_data` at `dm_addr`=w-1-NREGS. Total bytes: 4·(1+NREGS+DM_WORDS), which is 260 at the defaults.
- Byte order within a word is MSB first: `tx_data` is taken from shift[31:24], and the shift register moves left 8 bits after each byte.
- `rf_addr` and `dm_addr` are registered. Each is updated only in ADDR for its own segment and holds its value otherwise.
- States:
  - IDLE: wait for `send_flag`=1. On it, w←0, byte_cnt←0, go to ADDR.
  - ADDR: drive the address for w. Go to LOAD.
  - LOAD: shift ← `pc`, `rf_data` or `dm_data` according to w. Go to START.
  - START: `tx_start`=1 and `tx_data`=shift[31:24] for this one cycle. Go to WAIT.
  - WAIT: hold `tx_data`. On `tx_done`:
    - if byte_cnt<3: shift<<8, byte_cnt+1, go to START.
    - else if w = last word: go to DONE.
    - else: w+1, byte_cnt←0, go to ADDR.
  - DONE: `send_done`=1 for one cycle. Go to HOLD.
  - HOLD: wait for `send_flag`=0, then go to IDLE. This prevents a second frame from a still-high `send_flag`.
- `tx_done` is ignored in every state except WAIT.
- A fall of `send_flag` mid-frame is ignored; the frame always completes. Only `reset` aborts a frame.
- Reset (`reset`=0), asynchronous and effective immediately, including mid-frame:
  - state←IDLE, w=0, byte_cnt=0, shift=0.
  - `tx_start`=0, `tx_data`=0, `send_done`=0, `rf_addr`=0, `dm_addr`=0.
  - A partially sent frame is dropped. The next `send_flag` restarts from PC.

## Timing
- `send_flag` sampled high in IDLE at edge k: ADDR in cycle k+1, LOAD in k+2, `tx_start` high in cycle k+3.
- `tx_done` sampled in WAIT at edge e:
  - next byte of the same word: `tx_start` high in cycle e+1.
  - next word: ADDR e+1, LOAD e+2, `tx_start` e+3.
  - last byte of the frame: `send_done` high in cycle e+1, exactly one cycle.
- `tx_data` is stable from its `tx_start` cycle until the accepting `tx_done`.
- `tx_start` and `send_done` are never high in the same cycle. At most one `tx_start` is outstanding.
- w is wide enough for 1+NREGS+DM_WORDS words. Addresses are the truncated w offsets; there is no wrap inside a frame.

## Test plan
- Bench setup for the first three scenarios: NREGS=4, DM_WORDS=2, `pc`=0x00000010, regs=0x11111111·(i+1), mem=0xA0000000+i, tx model returns `tx_done` 10 cycles after `tx_start` -> 28 bytes: 00,00,00,10,11,11,11,11,22,… ending A0,00,00,01; `send_done` pulses once.
- Reg0=0xA1B2C3D4 -> bytes 5..8 are A1,B2,C3,D4. `rf_addr` sequence is 0,1,2,3 and `dm_addr` sequence is 0,1, each presented one cycle before LOAD.
- `send_flag` held high 6 cycles after `send_done` -> no new `tx_start`. Drop it and raise it again -> a second identical frame.
- `reset`=0 during byte 10 -> all outputs 0 in the same cycle. Release, then raise `send_flag` -> first byte is PC[31:24].
- `tx_done` pulses injected in IDLE, ADDR and START, plus `send_flag` dropped mid-frame -> byte count and order unchanged, frame completes.
- `tx_done` with 1-cycle latency -> `tx_start` spacing within a word is 3 cycles (START, WAIT, next START) and 5 cycles across words.
